// File: rtl/obj_pkg.sv
// Shared definitions for the proximity-sensor scan controller.
package obj_pkg;

    localparam logic [1:0] FRONT = 2'd0;
    localparam logic [1:0] LEFT  = 2'd1;
    localparam logic [1:0] RIGHT = 2'd2;
    localparam logic [1:0] BACK  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRIG   = 2'd1,
        LISTEN = 2'd2,
        GAP    = 2'd3
    } scan_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/obj_confirm_filter.sv
// Per-sensor debounce: the flag toggles only after CONFIRM consecutive
// committed results that disagree with it.
module obj_confirm_filter #(
    parameter int CONFIRM = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic commit,
    input  logic hit,
    output logic flag
);

    localparam int CNT_W = $clog2(CONFIRM + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag <= 1'b0;
            cnt  <= '0;
        end else if (commit) begin
            if (hit == flag) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(CONFIRM - 1)) begin
                flag <= ~flag;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/obj_scan_ctrl.sv
// Round-robin trigger/listen scheduler for four ranging sensors with
// per-sensor confirmation filtering of the echo results.
//
// state  | meaning
// IDLE   | scan stopped, sel holds the next sensor to fire
// TRIG   | trigger pulse on sensor sel
// LISTEN | echo window for sensor sel, hit accumulates
// GAP    | dead time before the next slot
module obj_scan_ctrl
    import obj_pkg::*;
#(
    parameter int TRIG_CYCLES   = 10,
    parameter int WINDOW_CYCLES = 64,
    parameter int GAP_CYCLES    = 16,
    parameter int CONFIRM       = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] echo,
    output logic [3:0] trig,
    output logic [1:0] sel,
    output logic       front_sensor,
    output logic       left_sensor,
    output logic       right_sensor,
    output logic       back_sensor,
    output logic       frame_done,
    output logic       busy
);

    localparam int CTR_W = $clog2(max3(TRIG_CYCLES, WINDOW_CYCLES, GAP_CYCLES) + 1);
    localparam logic [CTR_W-1:0] TRIG_LOAD = CTR_W'(TRIG_CYCLES - 1);
    localparam logic [CTR_W-1:0] WIN_LOAD  = CTR_W'(WINDOW_CYCLES - 1);
    localparam logic [CTR_W-1:0] GAP_LOAD  = CTR_W'(GAP_CYCLES - 1);

    scan_state_t      state, state_nxt;
    logic [CTR_W-1:0] ctr, ctr_nxt;
    logic [1:0]       sel_nxt;
    logic             hit, hit_nxt, hit_commit;
    logic             commit;
    logic [3:0]       trig_nxt;
    logic             busy_nxt, frame_done_nxt;
    logic [3:0]       flags;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ctr        <= '0;
            sel        <= FRONT;
            hit        <= 1'b0;
            trig       <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            ctr        <= ctr_nxt;
            sel        <= sel_nxt;
            hit        <= hit_nxt;
            trig       <= trig_nxt;
            busy       <= busy_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ctr_nxt   = ctr - CTR_W'(1);
        sel_nxt   = sel;
        case (state)
            IDLE: begin
                ctr_nxt = TRIG_LOAD;
                if (enable) state_nxt = TRIG;
            end
            TRIG: begin
                if (ctr == '0) begin
                    state_nxt = LISTEN;
                    ctr_nxt   = WIN_LOAD;
                end
            end
            LISTEN: begin
                if (ctr == '0) begin
                    state_nxt = GAP;
                    ctr_nxt   = GAP_LOAD;
                end
            end
            GAP: begin
                if (ctr == '0) begin
                    sel_nxt   = sel + 2'd1;
                    ctr_nxt   = TRIG_LOAD;
                    state_nxt = enable ? TRIG : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they register in step with it.
    always_comb begin
        commit         = (state == LISTEN) && (ctr == '0);
        hit_commit     = hit | echo[sel];
        hit_nxt        = (state == LISTEN) && !commit ? hit_commit : 1'b0;
        trig_nxt       = (state_nxt == TRIG) ? (4'b0001 << sel_nxt) : 4'b0000;
        busy_nxt       = (state_nxt != IDLE);
        frame_done_nxt = (state == GAP) && (ctr == '0) && (sel == BACK);
    end

    for (genvar i = 0; i < 4; i++) begin : g_filter
        obj_confirm_filter #(.CONFIRM(CONFIRM)) u_filter (
            .clk    (clk),
            .reset  (reset),
            .commit (commit && (sel == 2'(i))),
            .hit    (hit_commit),
            .flag   (flags[i])
        );
    end

    assign front_sensor = flags[FRONT];
    assign left_sensor  = flags[LEFT];
    assign right_sensor = flags[RIGHT];
    assign back_sensor  = flags[BACK];

endmodule

// File: tb/tb_obj_scan_ctrl.sv
// Directed bench for obj_scan_ctrl with TRIG=2, WINDOW=4, GAP=1, CONFIRM=2
// (slot = 7 cycles, frame = 28 cycles, cycle 1 = first TRIG cycle after reset).
module tb_obj_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] echo = 4'b0000;
    logic [3:0] trig;
    logic [1:0] sel;
    logic       front_sensor, left_sensor, right_sensor, back_sensor;
    logic       frame_done, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pulses;

    obj_scan_ctrl #(
        .TRIG_CYCLES(2), .WINDOW_CYCLES(4), .GAP_CYCLES(1), .CONFIRM(2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .echo         (echo),
        .trig         (trig),
        .sel          (sel),
        .front_sensor (front_sensor),
        .left_sensor  (left_sensor),
        .right_sensor (right_sensor),
        .back_sensor  (back_sensor),
        .frame_done   (frame_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc%0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step(1);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        cyc = 0;
    endtask

    function automatic logic [3:0] flag_vec();
        return {back_sensor, right_sensor, left_sensor, front_sensor};
    endfunction

    initial begin
        // 1: reset values and first trigger timing
        enable = 1'b1;
        echo   = 4'b1111;
        apply_reset();
        check_val("rst_trig", trig, 4'b0000);
        check_val("rst_sel", sel, 2'd0);
        check_val("rst_flags", flag_vec(), 4'b0000);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_fd", frame_done, 1'b0);
        step(1);
        check_val("t1_trig_c1", trig, 4'b0001);
        check_val("t1_busy_c1", busy, 1'b1);
        step(1);
        check_val("t1_trig_c2", trig, 4'b0001);
        step(1);
        check_val("t1_trig_listen", trig, 4'b0000);
        run_to(7);
        check_val("t1_trig_gap", trig, 4'b0000);
        step(1);
        check_val("t1_trig_left", trig, 4'b0010);
        check_val("t1_sel_left", sel, 2'd1);

        // 2 + 4: front echo held for two frames, then removed for two frames
        echo = 4'b0001;
        apply_reset();
        run_to(7);
        check_val("t2_front_f1", front_sensor, 1'b0);
        run_to(28);
        check_val("t2_fd_before", frame_done, 1'b0);
        step(1);
        check_val("t2_fd_pulse", frame_done, 1'b1);
        check_val("t2_sel_wrap", sel, 2'd0);
        step(1);
        check_val("t2_fd_after", frame_done, 1'b0);
        run_to(34);
        check_val("t2_front_pre", front_sensor, 1'b0);
        step(1);
        check_val("t2_front_rise", front_sensor, 1'b1);
        check_val("t2_others", flag_vec(), 4'b0001);
        echo = 4'b0000;
        run_to(63);
        check_val("t4_front_f3", front_sensor, 1'b1);
        run_to(90);
        check_val("t4_front_pre", front_sensor, 1'b1);
        step(1);
        check_val("t4_front_fall", front_sensor, 1'b0);

        // 3: single-cycle front echo in frame 1 only; counter must clear
        echo = 4'b0000;
        apply_reset();
        run_to(4);
        echo = 4'b0001;
        step(1);
        echo = 4'b1110;
        run_to(7);
        check_val("t3_front_f1", front_sensor, 1'b0);
        echo = 4'b0000;
        run_to(35);
        check_val("t3_front_f2", front_sensor, 1'b0);
        echo = 4'b0001;
        run_to(63);
        check_val("t3_cnt_cleared", front_sensor, 1'b0);
        run_to(91);
        check_val("t3_front_f4", front_sensor, 1'b1);
        check_val("t3_others", flag_vec(), 4'b0001);

        // 5: stop mid-slot, resume from the next sensor
        echo = 4'b0000;
        apply_reset();
        run_to(11);
        enable = 1'b0;
        run_to(14);
        check_val("t5_busy_gap", busy, 1'b1);
        step(1);
        check_val("t5_busy_idle", busy, 1'b0);
        check_val("t5_sel_idle", sel, 2'd2);
        check_val("t5_trig_idle", trig, 4'b0000);
        run_to(17);
        check_val("t5_hold_idle", busy, 1'b0);
        enable = 1'b1;
        pulses = 0;
        step(1);
        check_val("t5_trig_resume", trig, 4'b0100);
        while (cyc < 45) begin
            if (frame_done) pulses++;
            if (cyc == 31) check_val("t5_fd_pre", frame_done, 1'b0);
            if (cyc == 32) check_val("t5_fd_pulse", frame_done, 1'b1);
            step(1);
        end
        check_val("t5_fd_count", pulses, 1);

        // 6: asynchronous reset in the middle of a LISTEN
        echo = 4'b0001;
        apply_reset();
        run_to(35);
        check_val("t6_front_set", front_sensor, 1'b1);
        run_to(39);
        echo = 4'b1111;
        #2 reset = 1'b1;
        #1;
        check_val("t6_async_trig", trig, 4'b0000);
        check_val("t6_async_sel", sel, 2'd0);
        check_val("t6_async_flags", flag_vec(), 4'b0000);
        check_val("t6_async_busy", busy, 1'b0);
        step(1);
        reset = 1'b0;
        cyc = 0;
        step(1);
        check_val("t6_restart_trig", trig, 4'b0001);
        check_val("t6_restart_sel", sel, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
